dac_spi_tx: RTL



---
 rtl/dac_spi_tx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises one 32-bit LTC2624 command frame (MSB first) per start request.
// Define DAC_READBACK_EN to capture the DAC's SDO echo into readback/rb_mismatch.
module dac_spi_tx #(
    parameter int CS_HIGH_TICKS = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clockenable,
    input  logic        start,
    input  logic [3:0]  comando,
    input  logic [3:0]  canal,
    input  logic [11:0] datos,
    input  logic        miso,
    output logic        dac_cs_n,
    output logic        sck,
    output logic        mosi,
    output logic        dac_clr_n,
    output logic        busy,
    output logic        done
`ifdef DAC_READBACK_EN
    ,
    output logic [31:0] readback,
    output logic        rb_mismatch
`endif
);
    localparam int GW = (CS_HIGH_TICKS > 1) ? $clog2(CS_HIGH_TICKS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_HIGH_TICKS - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, END, GAP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   word_q, word_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          cs_n_q, cs_n_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          clr_n_q, clr_n_d;
    logic          fall_tick;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        clr_n_d   = 1'b1;
        fall_tick = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    word_d  = {8'h00, comando, canal, datos, 4'h0};
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (clockenable) begin
                    cs_n_d  = 1'b0;
                    mosi_d  = word_q[31];
                    sck_d   = 1'b0;
                    cnt_d   = 5'd31;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // mosi only moves on falling-sck ticks so it is stable at every rising edge
                if (clockenable) begin
                    sck_d = ~sck_q;
                    if (sck_q) begin
                        fall_tick = 1'b1;
                        if (cnt_q == 5'd0) begin
                            state_d = END;
                        end else begin
                            cnt_d  = cnt_q - 5'd1;
                            mosi_d = word_q[cnt_q - 5'd1];
                        end
                    end
                end
            end
            END: begin
                if (clockenable) begin
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (clockenable) begin
                    if (gap_q == GAP_LAST) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clr_n_q <= clr_n_d;
        end
    end

    assign dac_cs_n  = cs_n_q;
    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dac_clr_n = clr_n_q;

`ifdef DAC_READBACK_EN
    logic [31:0] rx_q, rx_d;
    logic [31:0] readback_q, readback_d;
    logic [31:0] prev_q, prev_d;
    logic        mismatch_q, mismatch_d;
    logic        have_prev_q, have_prev_d;

    // The DAC echoes the previous frame, so compare against the word sent last time
    always_comb begin
        rx_d        = rx_q;
        readback_d  = readback_q;
        prev_d      = prev_q;
        mismatch_d  = mismatch_q;
        have_prev_d = have_prev_q;
        if (fall_tick) begin
            rx_d = {rx_q[30:0], miso};
        end
        if (done_d) begin
            readback_d  = rx_q;
            mismatch_d  = have_prev_q && (rx_q != prev_q);
            prev_d      = word_q;
            have_prev_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_q        <= '0;
            readback_q  <= '0;
            prev_q      <= '0;
            mismatch_q  <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            rx_q        <= rx_d;
            readback_q  <= readback_d;
            prev_q      <= prev_d;
            mismatch_q  <= mismatch_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign readback    = readback_q;
    assign rb_mismatch = mismatch_q;
`else
    logic [1:0] unused_sigs;
    assign unused_sigs = {miso, fall_tick};
`endif

endmodule
